// File: rtl/boa_ex_stage.sv
// boa_ex_stage: RV32IM execute stage computing ALU/M results, addresses and branch outcomes
// into the EX/MEM barrier registers.
module boa_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        d_valid,
  input  logic [30:0] d_pc,
  input  logic [31:0] d_insn,
  input  logic        d_use_rd,
  input  logic [31:0] d_rs1_val,
  input  logic [31:0] d_rs2_val,
  input  logic        d_branch,
  input  logic        d_branch_predict,
  input  logic        d_trap,
  input  logic [3:0]  d_cause,
  output logic        q_valid,
  output logic [30:0] q_pc,
  output logic [31:0] q_insn,
  output logic        q_use_rd,
  output logic [31:0] q_rs1_val,
  output logic [31:0] q_rs2_val,
  output logic        q_trap,
  output logic [3:0]  q_cause,
  output logic        fw_branch_correct,
  input  logic        fw_stall_ex,
  output logic        fw_rd_ex
);
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [31:0] pc, a, b, imm_i, imm_s, imm_u, alu_b, sra_res, alu_res;
  logic [4:0]  shamt;
  logic        is_op, is_m;
  logic [63:0] mul_a, mul_b, prod;
  logic        div_s, a_neg, b_neg;
  logic [31:0] da, db, uq, ur, quo, rem, m_res, rs1_val_d;
  logic        taken;
  assign opc   = d_insn[6:0];
  assign f3    = d_insn[14:12];
  assign pc    = {d_pc, 1'b0};
  assign a     = d_rs1_val;
  assign b     = d_rs2_val;
  assign imm_i = {{20{d_insn[31]}}, d_insn[31:20]};
  assign imm_s = {{20{d_insn[31]}}, d_insn[31:25], d_insn[11:7]};
  assign imm_u = {d_insn[31:12], 12'h000};
  assign is_op = opc == 7'b0110011;
  assign is_m  = is_op && d_insn[31:25] == 7'b0000001;
  assign alu_b = is_op ? b : imm_i;
  assign shamt = alu_b[4:0];
  assign sra_res = $signed(a) >>> shamt;
  always_comb begin
    alu_res = a & alu_b;
    case (f3)
      3'd0: alu_res = (is_op & d_insn[30]) ? a - alu_b : a + alu_b;
      3'd1: alu_res = a << shamt;
      3'd2: alu_res = {31'b0, $signed(a) < $signed(alu_b)};
      3'd3: alu_res = {31'b0, a < alu_b};
      3'd4: alu_res = a ^ alu_b;
      3'd5: alu_res = d_insn[30] ? sra_res : a >> shamt;
      3'd6: alu_res = a | alu_b;
      default: alu_res = a & alu_b;
    endcase
  end
  // One 64-bit multiplier; operand extension picks MULH/MULHSU/MULHU signedness.
  assign mul_a = {{32{a[31] & (f3 == 3'd1 || f3 == 3'd2)}}, a};
  assign mul_b = {{32{b[31] & (f3 == 3'd1)}}, b};
  assign prod  = mul_a * mul_b;
  // Magnitude divide with sign fix-up; 0x80000000/-1 falls out naturally.
  assign div_s = ~f3[0];
  assign a_neg = div_s & a[31];
  assign b_neg = div_s & b[31];
  assign da    = a_neg ? -a : a;
  assign db    = b_neg ? -b : b;
  assign uq    = da / db;
  assign ur    = da % db;
  assign quo   = (b == 32'h0) ? 32'hFFFF_FFFF : ((a_neg ^ b_neg) ? -uq : uq);
  assign rem   = (b == 32'h0) ? a : (a_neg ? -ur : ur);
  assign m_res = f3[2] ? (f3[1] ? rem : quo) : ((f3[1:0] == 2'b00) ? prod[31:0] : prod[63:32]);
  always_comb begin
    rs1_val_d = a;
    case (opc)
      7'b0010011: rs1_val_d = alu_res;
      7'b0110011: rs1_val_d = is_m ? m_res : alu_res;
      7'b0110111: rs1_val_d = imm_u;
      7'b0010111: rs1_val_d = pc + imm_u;
      7'b1101111, 7'b1100111: rs1_val_d = pc + 32'd4;
      7'b0000011: rs1_val_d = a + imm_i;
      7'b0100011: rs1_val_d = a + imm_s;
      7'b1100011: rs1_val_d = 32'h0;
      default: rs1_val_d = a;
    endcase
  end
  always_comb begin
    taken = 1'b0;
    case (f3)
      3'd0: taken = a == b;
      3'd1: taken = a != b;
      3'd4: taken = $signed(a) < $signed(b);
      3'd5: taken = $signed(a) >= $signed(b);
      3'd6: taken = a < b;
      3'd7: taken = a >= b;
      default: taken = 1'b0;
    endcase
  end
  assign fw_branch_correct = d_valid & d_branch & ~d_trap & ~fw_stall_ex & ~clear &
                             (taken != d_branch_predict);
  assign fw_rd_ex = q_valid & q_use_rd & ~q_trap &
                    q_insn[6:0] != 7'b0000011 & q_insn[6:0] != 7'b1110011;
  // A clear overrides a stall so the squash always lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_valid   <= 1'b0;
      q_pc      <= '0;
      q_insn    <= '0;
      q_use_rd  <= 1'b0;
      q_rs1_val <= '0;
      q_rs2_val <= '0;
      q_trap    <= 1'b0;
      q_cause   <= '0;
    end else if (clear | ~fw_stall_ex) begin
      q_valid   <= d_valid & ~clear;
      q_pc      <= d_pc;
      q_insn    <= d_insn;
      q_use_rd  <= d_use_rd;
      q_rs1_val <= rs1_val_d;
      q_rs2_val <= d_rs2_val;
      q_trap    <= d_trap;
      q_cause   <= d_cause;
    end
  end
endmodule

// File: tb/tb_boa_ex_stage.sv
// tb_boa_ex_stage: randomized scoreboard bench for boa_ex_stage against an arithmetic reference model.
module tb_boa_ex_stage;
  logic clk = 0;
  logic rst, clear, d_valid, d_use_rd, d_branch, d_branch_predict, d_trap, fw_stall_ex;
  logic [30:0] d_pc;
  logic [31:0] d_insn, d_rs1_val, d_rs2_val;
  logic [3:0]  d_cause;
  logic q_valid, q_use_rd, q_trap, fw_branch_correct, fw_rd_ex;
  logic [30:0] q_pc;
  logic [31:0] q_insn, q_rs1_val, q_rs2_val;
  logic [3:0]  q_cause;

  always #5 clk = ~clk;

  boa_ex_stage dut (
    .clk(clk), .rst(rst), .clear(clear), .d_valid(d_valid), .d_pc(d_pc), .d_insn(d_insn),
    .d_use_rd(d_use_rd), .d_rs1_val(d_rs1_val), .d_rs2_val(d_rs2_val), .d_branch(d_branch),
    .d_branch_predict(d_branch_predict), .d_trap(d_trap), .d_cause(d_cause),
    .q_valid(q_valid), .q_pc(q_pc), .q_insn(q_insn), .q_use_rd(q_use_rd),
    .q_rs1_val(q_rs1_val), .q_rs2_val(q_rs2_val), .q_trap(q_trap), .q_cause(q_cause),
    .fw_branch_correct(fw_branch_correct), .fw_stall_ex(fw_stall_ex), .fw_rd_ex(fw_rd_ex)
  );

  // chk=0 means only valid-derived outputs are defined (after a squash)
  typedef struct {
    logic        chk;
    logic        valid;
    logic [30:0] pc;
    logic [31:0] insn;
    logic        use_rd;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        trap;
    logic [3:0]  cause;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic model_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa, sb2;
    sa = a;
    sb2 = b;
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb2;
      3'd5: return sa >= sb2;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_alu(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                                            input logic sub, input logic arith);
    int sx, sy;
    sx = x;
    sy = y;
    case (f)
      3'd0: return sub ? x - y : x + y;
      3'd1: return x << y[4:0];
      3'd2: return (sx < sy) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: begin
        if (arith) return sx >>> y[4:0];
        return x >> y[4:0];
      end
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic logic [31:0] model_m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa, sb2;
    longint p;
    logic [63:0] u;
    sa = a;
    sb2 = b;
    case (f)
      3'd0: begin p = longint'(sa) * longint'(sb2); return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb2); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'h0, b}); return p[63:32]; end
      3'd3: begin u = {32'h0, a} * {32'h0, b}; return u[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb2;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb2;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] model_res(input logic [31:0] pc, input logic [31:0] i,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ii, is, iu;
    ii = {{20{i[31]}}, i[31:20]};
    is = {{20{i[31]}}, i[31:25], i[11:7]};
    iu = {i[31:12], 12'h0};
    case (i[6:0])
      7'h13: return model_alu(i[14:12], a, ii, 1'b0, i[30]);
      7'h33: begin
        if (i[31:25] == 7'h01) return model_m(i[14:12], a, b);
        return model_alu(i[14:12], a, b, i[30], i[30]);
      end
      7'h37: return iu;
      7'h17: return pc + iu;
      7'h6f, 7'h67: return pc + 4;
      7'h03: return a + ii;
      7'h23: return a + is;
      7'h63: return 32'h0;
      default: return a;
    endcase
  endfunction

  function automatic logic [31:0] rv();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] i;
    i = $urandom;
    case ($urandom % 12)
      0, 1: begin
        i[6:0] = 7'h13;
        if (i[13:12] == 2'b01) i[31:25] = (i[14] & i[30]) ? 7'h20 : 7'h00;
      end
      2: begin
        i[31:25] = ((i[14:12] == 3'd0 || i[14:12] == 3'd5) && i[30]) ? 7'h20 : 7'h00;
        i[6:0] = 7'h33;
      end
      3, 4: begin i[31:25] = 7'h01; i[6:0] = 7'h33; end
      5: i[6:0] = 7'h37;
      6: i[6:0] = 7'h17;
      7: i[6:0] = 7'h6f;
      8: i[6:0] = 7'h67;
      9: i[6:0] = 7'h63;
      10: i[6:0] = i[31] ? 7'h03 : 7'h23;
      default: i[6:0] = i[30] ? 7'h73 : 7'h0f;
    endcase
    return i;
  endfunction

  task automatic drive(input logic r, input logic cl, input logic st, input logic v, input logic br,
                       input logic pr, input logic tr, input logic ur, input logic [3:0] ca,
                       input logic [30:0] pc, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b);
    logic bc;
    @(negedge clk);
    rst = r; clear = cl; fw_stall_ex = st; d_valid = v; d_branch = br; d_branch_predict = pr;
    d_trap = tr; d_use_rd = ur; d_cause = ca; d_pc = pc; d_insn = ins; d_rs1_val = a; d_rs2_val = b;
    #1;
    bc = v & br & !tr & !st & !cl & (model_taken(ins[14:12], a, b) != pr);
    cmp("fw_branch_correct", 32'(fw_branch_correct), 32'(bc));
    if (!r) m = '{1'b1, 1'b0, 31'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0};
    else if (cl) begin m.valid = 1'b0; m.chk = 1'b0; end
    else if (!st) m = '{1'b1, v, pc, ins, ur, model_res({pc, 1'b0}, ins, a, b), b, tr, ca};
    sb.push_back(m);
  endtask

  task automatic op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    drive(1, 0, 0, 1, 0, 0, 0, 1, 4'h0, 31'($urandom), ins, a, b);
  endtask

  task automatic br_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic pr, input logic tr, input logic st);
    drive(1, 0, st, 1, 1, pr, tr, 0, 4'h0, 31'($urandom), ins, a, b);
  endtask

  initial begin : monitor
    exp_t e;
    logic fr;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        fr = e.valid & e.use_rd & !e.trap & e.insn[6:0] != 7'h03 & e.insn[6:0] != 7'h73;
        cmp("q_valid", 32'(q_valid), 32'(e.valid));
        cmp("fw_rd_ex", 32'(fw_rd_ex), 32'(fr));
        if (e.chk) begin
          cmp("q_pc", 32'(q_pc), 32'(e.pc));
          cmp("q_insn", q_insn, e.insn);
          cmp("q_use_rd", 32'(q_use_rd), 32'(e.use_rd));
          cmp("q_rs1_val", q_rs1_val, e.r1);
          cmp("q_rs2_val", q_rs2_val, e.r2);
          cmp("q_trap", 32'(q_trap), 32'(e.trap));
          cmp("q_cause", 32'(q_cause), 32'(e.cause));
        end
      end
    end
  end

  initial begin
    rst = 0; clear = 0; fw_stall_ex = 0; d_valid = 0; d_branch = 0; d_branch_predict = 0;
    d_trap = 0; d_use_rd = 0; d_cause = 0; d_pc = 0; d_insn = 0; d_rs1_val = 0; d_rs2_val = 0;
    repeat (2) drive(0, $urandom, $urandom, $urandom, 0, $urandom, $urandom, $urandom, 4'($urandom),
                     31'($urandom), $urandom, $urandom, $urandom);
    op({7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33}, 5, 7);
    op({7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33}, 5, 7);
    op({7'h20, 5'd4, 5'd1, 3'd5, 5'd3, 7'h13}, 32'h8000_0000, 0);
    op({7'h01, 5'd2, 5'd1, 3'd4, 5'd3, 7'h33}, 7, 0);
    op({7'h01, 5'd2, 5'd1, 3'd6, 5'd3, 7'h33}, 7, 0);
    op({7'h01, 5'd2, 5'd1, 3'd4, 5'd3, 7'h33}, 32'h8000_0000, 32'hFFFF_FFFF);
    op({7'h01, 5'd2, 5'd1, 3'd6, 5'd3, 7'h33}, 32'h8000_0000, 32'hFFFF_FFFF);
    op({7'h01, 5'd2, 5'd1, 3'd3, 5'd3, 7'h33}, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    br_op({7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h63}, 3, 3, 0, 0, 0);
    br_op({7'h00, 5'd2, 5'd1, 3'd4, 5'd0, 7'h63}, 32'hFFFF_FFFF, 1, 1, 0, 0);
    br_op({7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h63}, 3, 3, 0, 1, 0);
    br_op({7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h63}, 3, 3, 0, 0, 1);
    op({12'hFFC, 5'd1, 3'd2, 5'd3, 7'h03}, 32'h100, 0);
    drive(1, 0, 0, 1, 0, 0, 0, 1, 4'h0, 31'h2000_0008, {20'h0, 5'd1, 7'h6f}, 0, 0);
    drive(1, 0, 1, 1, 0, 0, 0, 1, 4'h0, 31'h1234, {7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33}, 1, 2);
    drive(1, 0, 1, 0, 0, 0, 1, 0, 4'h5, 31'h5678, {7'h00, 5'd2, 5'd1, 3'd4, 5'd3, 7'h33}, 9, 9);
    drive(1, 1, 1, 1, 1, 0, 0, 1, 4'h0, 31'h9, {7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h63}, 3, 3);
    drive(1, 0, 1, 1, 0, 0, 0, 1, 4'h0, 31'h9, {7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33}, 3, 3);
    for (int k = 0; k < 600; k++) begin
      logic [31:0] ins;
      ins = rand_insn();
      drive(($urandom % 60) != 0, ($urandom % 10) == 0, ($urandom % 6) == 0, ($urandom % 8) != 0,
            ins[6:0] == 7'h63 ? 1'b1 : (($urandom % 16) == 0), $urandom, ($urandom % 10) == 0,
            $urandom, 4'($urandom), 31'($urandom), ins, rv(), rv());
    end
    repeat (2) @(posedge clk);
    #3;
    cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/boa_ex_stage.md
Name: boa_ex_stage

Overview:
Execute stage of the Boa³² 5-stage RV32IM_Zicsr pipeline (IF, ID, EX, MEM, WB), between the ID/EX and EX/MEM barriers.
- Computes ALU/M-extension results, load/store addresses, link values and conditional-branch outcomes.
- Flags branch mispredictions back to IF/ID and tells the hazard unit whether its registered result can be forwarded.
- Drives the EX/MEM barrier registers.

Parameters:
none

Ports:
clk  in  1  CPU clock
rst  in  1  synchronous reset, active-low (rst=0 resets)
clear  in  1  squash: next q_valid=0
d_valid  in  1  ID/EX entry valid
d_pc  in  31  instruction PC[31:1]
d_insn  in  32  instruction word
d_use_rd  in  1  instruction writes rd
d_rs1_val  in  32  RS1 value (already forwarded)
d_rs2_val  in  32  RS2 value (already forwarded)
d_branch  in  1  conditional branch
d_branch_predict  in  1  ID predicted taken
d_trap  in  1  trap raised upstream
d_cause  in  4  trap cause
q_valid  out  1  EX/MEM valid
q_pc  out  31  PC
q_insn  out  32  instruction
q_use_rd  out  1  writes rd
q_rs1_val  out  32  ALU result / memory address
q_rs2_val  out  32  store data (d_rs2_val)
q_trap  out  1  trap
q_cause  out  4  cause
fw_branch_correct  out  1  misprediction, combinational
fw_stall_ex  in  1  stall: hold EX/MEM registers
fw_rd_ex  out  1  q_rs1_val is the final rd value

Behaviour:
Reset and register update
- On posedge with rst=0: all q_* cleared to 0.
- Otherwise, if clear=1: q_valid<=0, other q_* don't-care. Clear has priority over stall.
- Else if fw_stall_ex=1: all q_* hold.
- Else all q_* load this cycle's results. q_pc, q_insn, q_use_rd, q_trap and q_cause pass straight through.
- Latency: 1 cycle.

Operand and immediate definitions
- PC = {d_pc,1'b0}.
- Immediates are standard RV32 I/S/U, sign-extended.

Result selection (q_rs1_val), by opcode d_insn[6:0]:
- OP-IMM 0010011: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI. SRAI is selected by insn[30]; shift amount is insn[24:20].
- OP 0110011, funct7 0000000/0100000: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. Shift amount is rs2[4:0].
- OP 0110011, funct7 0000001: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, all single-cycle combinational.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
- LUI: imm_u. AUIPC: PC+imm_u.
- JAL, JALR: PC+4 (link value).
- LOAD: rs1+imm_i. STORE: rs1+imm_s.
- BRANCH: result 0.
- SYSTEM, MISC-MEM and any other opcode: rs1 passthrough.
- q_rs2_val = d_rs2_val always.

Branch resolution
- taken per funct3: BEQ, BNE, BLT, BGE, BLTU, BGEU. funct3 010/011 evaluate as not taken.
- fw_branch_correct = d_valid & d_branch & !d_trap & !fw_stall_ex & !clear & (taken != d_branch_predict).
- It is combinational in the same cycle the branch occupies EX. Redirect targets are held outside this block.

Forwarding flag
- fw_rd_ex = q_valid & q_use_rd & !q_trap & opcode(q_insn) not LOAD (0000011) and not SYSTEM (1110011).
- This is combinational from the registers.

Traps
- d_trap is passed through. This block raises no new traps and suppresses branch correction for trapped entries.
- An invalid entry (d_valid=0) yields q_valid=0 and fw_branch_correct=0.

Test Plan:
1. rst=0 for 2 cycles with arbitrary inputs -> all q_*=0, fw_branch_correct=0, fw_rd_ex=0.
2. ADD x3 with rs1=5, rs2=7, then SUB -> q_rs1_val=12, then 0xFFFFFFFE; fw_rd_ex=1. SRAI 4 of 0x80000000 -> 0xF8000000.
3. DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000/-1 -> 0x80000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
4. BEQ rs1=rs2=3 with d_branch_predict=0 -> fw_branch_correct=1 in that cycle. BLT -1<1 with predict=1 -> 0. Same BEQ with d_trap=1 or fw_stall_ex=1 -> 0.
5. LW imm=-4, rs1=0x100 -> q_rs1_val=0xFC, fw_rd_ex=0. JAL at PC 0x40000010 -> q_rs1_val=0x40000014, fw_rd_ex=1.
6. fw_stall_ex=1 across an input change -> q_* hold. clear=1 with stall=1 -> q_valid=0 next cycle.
